sys_mem_responder: RTL and testbench

- Target-side model of the 16 KB system memory (8K x 16-bit words) that answers the processor memory interface unit's read_req/write_req handshake.
- Captures address and write data on an accepted request and waits a fixed LATENCY.
- Then performs the access and pulses mem_resp for one cycle.
- Waits for the initiator to drop its request before accepting the next one.

---
 rtl/sys_mem_responder.sv | 212 +++++++++++++++++++++
 tb/tb_sys_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_mem_responder.sv
// ---------------------------------------------------------------------------
// sys_mem_responder
//
// Target-side model of the 16 KB system memory (8K x 16-bit words). It
// answers the read_req/write_req level handshake of the processor memory
// interface unit:
//   - accepts a request in IDLE and captures word address, data and op,
//   - waits LATENCY cycles, then commits the access,
//   - pulses mem_resp for one cycle,
//   - waits until the initiator has dropped both requests before it can
//     accept another.
//
// Parameters
//   ADDR_W   byte address width (14 -> 16 KB)
//   DATA_W   memory word width (16)
//   LATENCY  acceptance edge to mem_resp sampling edge, legal 1..15
//
// Ports
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   read_req   level read request, held until mem_resp is seen
//   write_req  level write request, held until mem_resp is seen
//   addr       byte address; addr[ADDR_W-1:1] selects the word
//   datain     full-word write data
//   mem_resp   one-cycle completion pulse
//   dataout    read data; updated only when a read completes
//   busy       high whenever the FSM is not in IDLE
//   proto_err  sticky: both requests were high together in IDLE
// ---------------------------------------------------------------------------
module sys_mem_responder #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  output logic              mem_resp,
  output logic [DATA_W-1:0] dataout,
  output logic              busy,
  output logic              proto_err
);

  localparam int WORD_W = ADDR_W - 1;
  localparam int WORDS  = 1 << WORD_W;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_RELEASE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [WORD_W-1:0]  r_word;
  logic [DATA_W-1:0]  r_data;
  logic               r_is_wr;
  logic               r_mem_resp;
  logic [DATA_W-1:0]  r_dataout;
  logic               r_busy;
  logic               r_proto_err;

  logic [DATA_W-1:0]  r_mem [WORDS];

  logic               w_req;
  logic               w_accept;
  logic               w_wait_done;
  logic               w_commit;
  logic               w_commit_wr;
  logic [WORD_W-1:0]  w_commit_word;
  logic [DATA_W-1:0]  w_commit_data;
  logic               w_mem_we;

  assign w_req    = read_req | write_req;
  assign w_accept = (r_state == S_IDLE) && w_req;

  // The counter holds the number of edges still to go; the access commits on
  // the edge that would take it from 1 to 0. A request dropped on that same
  // edge still aborts.
  assign w_wait_done = (r_state == S_WAIT) && w_req && (r_count == CNT_W'(1));

  // With LATENCY=1 the access commits on the acceptance edge itself, so the
  // commit path must take address/data straight from the ports rather than
  // from the capture registers.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_commit      = 1'b0;
    w_commit_wr   = r_is_wr;
    w_commit_word = r_word;
    w_commit_data = r_data;
    if (LATENCY == 1) begin
      if (w_accept) begin
        w_commit      = 1'b1;
        w_commit_wr   = write_req;
        w_commit_word = addr[ADDR_W-1:1];
        w_commit_data = datain;
      end
    end else begin
      w_commit = w_wait_done;
    end
  end

  // Reset on the commit edge aborts the access, so the write is suppressed.
  assign w_mem_we = reset_n && w_commit && w_commit_wr;

  // NOTE: the memory array has no reset; its contents are undefined until
  // written, and a resettable 8K-entry array could not map onto RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_commit_word] <= w_commit_data;
    end
  end

  // Control FSM. All outputs are registered and set alongside the state
  // transition that makes them true.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_word      <= '0;
      r_data      <= '0;
      r_is_wr     <= 1'b0;
      r_mem_resp  <= 1'b0;
      r_dataout   <= '0;
      r_busy      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_mem_resp <= 1'b0;

      if (w_commit && !w_commit_wr) begin
        r_dataout <= r_mem[w_commit_word];
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_word  <= addr[ADDR_W-1:1];
            r_data  <= datain;
            // Simultaneous requests are served as a write and flagged.
            r_is_wr <= write_req;
            if (read_req && write_req) begin
              r_proto_err <= 1'b1;
            end
            r_busy <= 1'b1;
            if (LATENCY == 1) begin
              r_state    <= S_RESP;
              r_count    <= '0;
              r_mem_resp <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_count <= CNT_W'(LATENCY - 1);
            end
          end else begin
            r_busy <= 1'b0;
          end
        end

        S_WAIT: begin
          if (!w_req) begin
            // Initiator gave up: no commit, no response.
            r_state <= S_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
          end else if (r_count == CNT_W'(1)) begin
            r_state    <= S_RESP;
            r_count    <= '0;
            r_mem_resp <= 1'b1;
            r_busy     <= 1'b1;
          end else begin
            r_count <= r_count - CNT_W'(1);
            r_busy  <= 1'b1;
          end
        end

        S_RESP: begin
          r_state <= S_RELEASE;
          r_busy  <= 1'b1;
        end

        S_RELEASE: begin
          // The initiator may drop its request only on the edge where it
          // samples mem_resp, so hold here until it is seen low.
          if (!w_req) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_busy <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_resp  = r_mem_resp;
  assign dataout   = r_dataout;
  assign busy      = r_busy;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_sys_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_sys_mem_responder
//
// Three instances of sys_mem_responder (LATENCY 4, 1 and 15) driven from a
// transaction-level initiator. A per-instance word array plus a sticky error
// flag and the last read value form the reference model.
// ---------------------------------------------------------------------------
module tb_sys_mem_responder;

  localparam int NI = 3;

  logic        clk;
  logic        reset_n;
  logic        rd   [NI];
  logic        wr   [NI];
  logic [13:0] ad   [NI];
  logic [15:0] di   [NI];
  logic        mr   [NI];
  logic [15:0] dout [NI];
  logic        bz   [NI];
  logic        pe   [NI];

  int n_checks;
  int n_fail;

  // Reference model state.
  logic [15:0] mem_m     [NI][8192];
  bit          mem_v     [NI][8192];
  bit          pe_m      [NI];
  logic [15:0] last_m    [NI];
  bit          last_ok   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sys_mem_responder #(
      .ADDR_W (14),
      .DATA_W (16),
      .LATENCY((g == 0) ? 4 : (g == 1) ? 1 : 15)
    ) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .read_req (rd[g]),
      .write_req(wr[g]),
      .addr     (ad[g]),
      .datain   (di[g]),
      .mem_resp (mr[g]),
      .dataout  (dout[g]),
      .busy     (bz[g]),
      .proto_err(pe[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      pe_m[k]    = 1'b0;
      last_m[k]  = 16'h0000;
      last_ok[k] = 1'b1;
    end
  endtask

  // One complete transaction. Acceptance edge is the first posedge after the
  // request goes up; the initiator sees mem_resp on edge acceptance+LATENCY,
  // i.e. it is visible in the negedge sample following edge
  // acceptance+LATENCY-1. The request is then held for 'hold' more cycles.
  task automatic txn(input int k, input bit w, input bit r, input logic [13:0] a,
                     input logic [15:0] d, input int hold);
    int          n;
    bit          seen;
    logic [12:0] wd;
    wd = a[13:1];
    @(negedge clk);
    check("idle_before_req", bz[k], 1'b0);
    wr[k] = w;
    rd[k] = r;
    ad[k] = a;
    di[k] = d;
    if (w && r) pe_m[k] = 1'b1;
    @(posedge clk);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      check("busy_in_access", bz[k], 1'b1);
      if (mr[k]) begin
        seen = 1'b1;
      end else begin
        // Captured values must be used, not whatever is on the bus now.
        ad[k] = 14'($urandom);
        di[k] = 16'($urandom);
        @(posedge clk);
        n++;
      end
    end
    check("resp_seen", seen, 1'b1);
    if (seen) begin
      check("resp_latency", n + 1, lat_of(k));
      if (w) begin
        mem_m[k][wd] = d;
        mem_v[k][wd] = 1'b1;
        if (last_ok[k]) check("dataout_kept_on_write", dout[k], last_m[k]);
      end else if (mem_v[k][wd]) begin
        check("read_data", dout[k], mem_m[k][wd]);
        last_m[k]  = mem_m[k][wd];
        last_ok[k] = 1'b1;
      end else begin
        last_ok[k] = 1'b0;
      end
      check("proto_err", pe[k], pe_m[k]);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("no_second_resp", mr[k], 1'b0);
      check("busy_held", bz[k], 1'b1);
    end
    wr[k] = 1'b0;
    rd[k] = 1'b0;
    @(negedge clk);
    check("resp_single", mr[k], 1'b0);
    @(negedge clk);
    check("idle_after_release", bz[k], 1'b0);
    check("proto_err_sticky", pe[k], pe_m[k]);
  endtask

  initial begin
    logic [13:0] a;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    for (int k = 0; k < NI; k++) begin
      rd[k] = 1'b0;
      wr[k] = 1'b0;
      ad[k] = '0;
      di[k] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_mem_resp", mr[k], 1'b0);
      check("rst_dataout", dout[k], 16'h0000);
      check("rst_busy", bz[k], 1'b0);
      check("rst_proto_err", pe[k], 1'b0);
    end

    // Write then read.
    txn(0, 1, 0, 14'h0010, 16'hBEEF, 0);
    txn(0, 0, 1, 14'h0010, 16'h0000, 0);
    // Top-of-memory byte alias.
    txn(0, 1, 0, 14'h3FFE, 16'h1234, 0);
    txn(0, 0, 1, 14'h3FFF, 16'h0000, 0);
    // Held request after mem_resp.
    txn(0, 1, 0, 14'h0020, 16'h5555, 0);
    txn(0, 0, 1, 14'h0020, 16'h0000, 3);

    // Write aborted by dropping the request in WAIT.
    @(negedge clk);
    wr[0] = 1'b1;
    ad[0] = 14'h0020;
    di[0] = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", bz[0], 1'b1);
    wr[0] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_resp", mr[0], 1'b0);
    end
    check("abort_idle", bz[0], 1'b0);
    txn(0, 0, 1, 14'h0020, 16'h0000, 0);

    // Write aborted by reset in WAIT.
    @(negedge clk);
    wr[0] = 1'b1;
    ad[0] = 14'h0020;
    di[0] = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    wr[0]   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    check("midrst_mem_resp", mr[0], 1'b0);
    check("midrst_dataout", dout[0], 16'h0000);
    check("midrst_busy", bz[0], 1'b0);
    check("midrst_proto_err", pe[0], 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("midrst_no_resp", mr[0], 1'b0);
    end
    txn(0, 0, 1, 14'h0020, 16'h0000, 0);

    // Protocol error: both requests together are served as a write.
    txn(0, 1, 1, 14'h0040, 16'h0F0F, 0);
    txn(0, 0, 1, 14'h0040, 16'h0000, 1);

    // Single reads in the LATENCY=1 and LATENCY=15 instances.
    txn(1, 1, 0, 14'h0100, 16'hC0DE, 0);
    txn(1, 0, 1, 14'h0101, 16'h0000, 2);
    txn(2, 1, 0, 14'h0200, 16'h7E57, 0);
    txn(2, 0, 1, 14'h0200, 16'h0000, 1);

    // Randomized traffic over a small word pool so reads hit written words.
    for (int i = 0; i < 60; i++) begin
      int k;
      int op;
      k  = int'($urandom_range(0, NI - 1));
      op = int'($urandom_range(0, 15));
      a  = 14'h3F00 | 14'($urandom_range(0, 31));
      if (op == 0)
        txn(k, 1, 1, a, 16'($urandom), int'($urandom_range(0, 3)));
      else if (op < 8)
        txn(k, 1, 0, a, 16'($urandom), int'($urandom_range(0, 3)));
      else
        txn(k, 0, 1, a, 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
